// File: rtl/uart_alu_pkg.sv
// uart_alu_pkg
//   Constants shared by the UART/ALU sequencer and its result FIFO.
//   - Opcode values, which are MIPS function codes (6 bits).
//   - Frame-collector state encoding.
//   - Error cause codes reported on o_err_code.
//   - op_is_valid(): tells whether a 6-bit opcode selects a supported ALU operation.
package uart_alu_pkg;

  localparam logic [5:0] OP_ADD = 6'h20;
  localparam logic [5:0] OP_SUB = 6'h22;
  localparam logic [5:0] OP_AND = 6'h24;
  localparam logic [5:0] OP_OR  = 6'h25;
  localparam logic [5:0] OP_XOR = 6'h26;
  localparam logic [5:0] OP_NOR = 6'h27;
  localparam logic [5:0] OP_SRA = 6'h03;
  localparam logic [5:0] OP_SRL = 6'h02;

  localparam logic [1:0] GET_A  = 2'd0;
  localparam logic [1:0] GET_B  = 2'd1;
  localparam logic [1:0] GET_OP = 2'd2;
  localparam logic [1:0] EXEC   = 2'd3;

  localparam logic [1:0] ERR_NONE = 2'b00;
  localparam logic [1:0] ERR_OP   = 2'b01;
  localparam logic [1:0] ERR_TMO  = 2'b10;
  localparam logic [1:0] ERR_OVR  = 2'b11;

  function automatic logic op_is_valid(input logic [5:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOR, OP_SRA, OP_SRL: op_is_valid = 1'b1;
      default:                                                       op_is_valid = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/uart_alu_sequencer_sync_fifo.sv
// sync_fifo
//   First-word-fall-through synchronous FIFO of 2**LOG_DEPTH entries.
//   Pointers carry one extra bit so that full and empty can be told apart.
//   A push and a pop in the same cycle are both performed, even when the FIFO is full.
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   push, push_data  write request and data
//   pop              read request (ignored when empty)
//   pop_data         head entry, 0 while empty
//   full, empty      status flags
//   count            number of stored entries (0 .. 2**LOG_DEPTH)
module sync_fifo #(
  parameter int NB_DATA   = 8,
  parameter int LOG_DEPTH = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               push,
  input  logic [NB_DATA-1:0] push_data,
  input  logic               pop,
  output logic [NB_DATA-1:0] pop_data,
  output logic               full,
  output logic               empty,
  output logic [LOG_DEPTH:0] count
);

  localparam int DEPTH = 1 << LOG_DEPTH;

  logic [NB_DATA-1:0] mem [DEPTH];
  logic [LOG_DEPTH:0] wr_ptr_reg;
  logic [LOG_DEPTH:0] rd_ptr_reg;
  logic               do_push;
  logic               do_pop;

  assign empty = (wr_ptr_reg == rd_ptr_reg);
  assign full  = (wr_ptr_reg[LOG_DEPTH] != rd_ptr_reg[LOG_DEPTH]) &&
                 (wr_ptr_reg[LOG_DEPTH-1:0] == rd_ptr_reg[LOG_DEPTH-1:0]);
  assign count = wr_ptr_reg - rd_ptr_reg;

  // A simultaneous pop frees the slot the push is about to use.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg[LOG_DEPTH-1:0]] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
    end
  end

  // The head is presented combinationally; gating keeps the output at 0 while empty.
  assign pop_data = empty ? '0 : mem[rd_ptr_reg[LOG_DEPTH-1:0]];

endmodule

// File: rtl/uart_alu_sequencer.sv
// uart_alu_sequencer
//   Collects {A, B, opcode} frames from a UART receiver byte stream, executes the
//   ALU operation and queues results in a FIFO that drains into a UART transmitter
//   through a valid/ready handshake. Detects inter-byte timeouts, bad opcodes and
//   bytes arriving while a frame is still executing (overrun).
//   Optional feature, macro UART_ALU_FLAGS_EN: each valid operation also pushes a
//   flags byte {0.., overflow, carry, zero} after its result.
// Ports:
//   i_clk        system clock
//   i_reset      asynchronous active-low reset
//   i_valid_rx   one-cycle pulse, i_data holds a received byte
//   i_data       received byte
//   i_ready_tx   transmitter can accept a byte
//   o_resultado  FIFO head byte
//   o_valid      FIFO non-empty
//   o_error      one-cycle pulse on a frame error
//   o_err_code   cause of the last error (01 opcode, 10 timeout, 11 overrun), held
//   o_busy       frame in progress
module uart_alu_sequencer
  import uart_alu_pkg::*;
#(
  parameter int NB_DATA        = 8,
  parameter int NB_OP          = 6,
  parameter int LOG_DEPTH      = 2,
  parameter int TIMEOUT_CYCLES = 800000
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_valid_rx,
  input  logic [NB_DATA-1:0] i_data,
  input  logic               i_ready_tx,
  output logic [NB_DATA-1:0] o_resultado,
  output logic               o_valid,
  output logic               o_error,
  output logic [1:0]         o_err_code,
  output logic               o_busy
);

  localparam int SHW   = $clog2(NB_DATA);
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES) + 1;

  logic [1:0]         state_reg, state_next;
  logic [NB_DATA-1:0] a_reg, a_next;
  logic [NB_DATA-1:0] b_reg, b_next;
  logic [NB_OP-1:0]   op_reg, op_next;
  logic [TMO_W-1:0]   tmo_cnt_reg, tmo_cnt_next;
  logic               error_reg, error_next;
  logic [1:0]         err_code_reg, err_code_next;

  logic               push;
  logic [NB_DATA-1:0] push_data;
  logic               pop;
  logic               fifo_full;
  logic               fifo_empty;
  logic [LOG_DEPTH:0] fifo_count;
  logic               tmo_hit;
  logic [5:0]         op6;

  function automatic logic [NB_DATA-1:0] alu(input logic [NB_DATA-1:0] a,
                                             input logic [NB_DATA-1:0] b,
                                             input logic [5:0]         op);
    logic [SHW-1:0] sh;
    sh = b[SHW-1:0];
    case (op)
      OP_ADD:  alu = a + b;
      OP_SUB:  alu = a - b;
      OP_AND:  alu = a & b;
      OP_OR:   alu = a | b;
      OP_XOR:  alu = a ^ b;
      OP_NOR:  alu = ~(a | b);
      OP_SRA:  alu = $signed(a) >>> sh;
      OP_SRL:  alu = a >> sh;
      default: alu = '0;
    endcase
  endfunction

`ifdef UART_ALU_FLAGS_EN
  logic               flag_phase_reg, flag_phase_next;
  logic [LOG_DEPTH+1:0] slots;

  function automatic logic [NB_DATA-1:0] alu_flags(input logic [NB_DATA-1:0] a,
                                                   input logic [NB_DATA-1:0] b,
                                                   input logic [5:0]         op);
    logic [NB_DATA:0]   wide;
    logic [NB_DATA-1:0] r;
    logic               c;
    logic               v;
    r    = alu(a, b, op);
    wide = '0;
    c    = 1'b0;
    v    = 1'b0;
    case (op)
      OP_ADD: begin
        wide = {1'b0, a} + {1'b0, b};
        c    = wide[NB_DATA];
        v    = (a[NB_DATA-1] == b[NB_DATA-1]) && (r[NB_DATA-1] != a[NB_DATA-1]);
      end
      OP_SUB: begin
        // Top bit of the widened difference is the borrow.
        wide = {1'b0, a} - {1'b0, b};
        c    = wide[NB_DATA];
        v    = (a[NB_DATA-1] != b[NB_DATA-1]) && (r[NB_DATA-1] != a[NB_DATA-1]);
      end
      default: ;
    endcase
    alu_flags      = '0;
    alu_flags[2:0] = {v, c, (r == '0)};
  endfunction

  // Free slots this cycle, counting a simultaneous pop as one freed slot.
  assign slots = (LOG_DEPTH+2)'(1 << LOG_DEPTH) - (LOG_DEPTH+2)'(fifo_count) + (LOG_DEPTH+2)'(pop);

  logic unused_full;
  assign unused_full = fifo_full;
`else
  logic unused_count;
  assign unused_count = ^fifo_count;
`endif

  assign op6     = 6'(op_reg);
  assign pop     = ~fifo_empty & i_ready_tx;
  assign tmo_hit = (tmo_cnt_reg == TMO_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    state_next    = state_reg;
    a_next        = a_reg;
    b_next        = b_reg;
    op_next       = op_reg;
    error_next    = 1'b0;
    err_code_next = err_code_reg;
    push          = 1'b0;
    push_data     = '0;
`ifdef UART_ALU_FLAGS_EN
    flag_phase_next = flag_phase_reg;
`endif

    case (state_reg)
      GET_A: begin
        if (i_valid_rx) begin
          a_next     = i_data;
          state_next = GET_B;
        end
      end
      GET_B: begin
        if (i_valid_rx) begin
          b_next     = i_data;
          state_next = GET_OP;
        end else if (tmo_hit) begin
          error_next    = 1'b1;
          err_code_next = ERR_TMO;
          state_next    = GET_A;
        end
      end
      GET_OP: begin
        if (i_valid_rx) begin
          op_next    = i_data[NB_OP-1:0];
          state_next = EXEC;
        end else if (tmo_hit) begin
          error_next    = 1'b1;
          err_code_next = ERR_TMO;
          state_next    = GET_A;
        end
      end
      default: begin // EXEC
        // The incoming byte is dropped; the frame being executed still completes.
        if (i_valid_rx) begin
          error_next    = 1'b1;
          err_code_next = ERR_OVR;
        end
        if (!op_is_valid(op6)) begin
          error_next    = 1'b1;
          err_code_next = ERR_OP;
          state_next    = GET_A;
        end else begin
`ifdef UART_ALU_FLAGS_EN
          // Two slots are reserved before the result goes in, so the flags
          // byte in the following cycle always finds room.
          if (flag_phase_reg) begin
            push            = 1'b1;
            push_data       = alu_flags(a_reg, b_reg, op6);
            flag_phase_next = 1'b0;
            state_next      = GET_A;
          end else if (slots >= (LOG_DEPTH+2)'(2)) begin
            push            = 1'b1;
            push_data       = alu(a_reg, b_reg, op6);
            flag_phase_next = 1'b1;
          end
`else
          if (!fifo_full || pop) begin
            push       = 1'b1;
            push_data  = alu(a_reg, b_reg, op6);
            state_next = GET_A;
          end
`endif
        end
      end
    endcase
  end

  // Counts only while waiting for B or the opcode; any accepted byte restarts it.
  always_comb begin
    if (i_valid_rx || tmo_hit || ((state_reg != GET_B) && (state_reg != GET_OP))) begin
      tmo_cnt_next = '0;
    end else begin
      tmo_cnt_next = tmo_cnt_reg + 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_reg    <= GET_A;
      a_reg        <= '0;
      b_reg        <= '0;
      op_reg       <= '0;
      tmo_cnt_reg  <= '0;
      error_reg    <= 1'b0;
      err_code_reg <= ERR_NONE;
`ifdef UART_ALU_FLAGS_EN
      flag_phase_reg <= 1'b0;
`endif
    end else begin
      state_reg    <= state_next;
      a_reg        <= a_next;
      b_reg        <= b_next;
      op_reg       <= op_next;
      tmo_cnt_reg  <= tmo_cnt_next;
      error_reg    <= error_next;
      err_code_reg <= err_code_next;
`ifdef UART_ALU_FLAGS_EN
      flag_phase_reg <= flag_phase_next;
`endif
    end
  end

  sync_fifo #(
    .NB_DATA   (NB_DATA),
    .LOG_DEPTH (LOG_DEPTH)
  ) u_fifo (
    .clk       (i_clk),
    .rst_n     (i_reset),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .pop_data  (o_resultado),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign o_valid    = ~fifo_empty;
  assign o_error    = error_reg;
  assign o_err_code = err_code_reg;
  assign o_busy     = (state_reg != GET_A);

endmodule

// File: tb/tb_uart_alu_sequencer.sv
// tb_uart_alu_sequencer
//   Scoreboard bench: stimulus pushes expected result bytes and error codes into
//   queues; an independent monitor pops and compares whenever the DUT pops a
//   result or pulses o_error. Expected values come from a plain-arithmetic model.
`timescale 1ns/1ps
module tb_uart_alu_sequencer;

  localparam int NB_DATA   = 8;
  localparam int NB_OP     = 6;
  localparam int LOG_DEPTH = 2;
  localparam int TMO       = 100;

  logic         i_clk      = 1'b0;
  logic         i_reset    = 1'b0;
  logic         i_valid_rx = 1'b0;
  logic [7:0]   i_data     = 8'h00;
  logic         i_ready_tx = 1'b0;
  logic [7:0]   o_resultado;
  logic         o_valid;
  logic         o_error;
  logic [1:0]   o_err_code;
  logic         o_busy;

  int tests    = 0;
  int fails    = 0;
  int cyc      = 0;
  int err_seen = 0;
  int err_cyc  = 0;
  bit tx_en    = 1'b0;
  logic [7:0] exp_q[$];
  logic [1:0] err_q[$];

  uart_alu_sequencer #(
    .NB_DATA        (NB_DATA),
    .NB_OP          (NB_OP),
    .LOG_DEPTH      (LOG_DEPTH),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_valid_rx  (i_valid_rx),
    .i_data      (i_data),
    .i_ready_tx  (i_ready_tx),
    .o_resultado (o_resultado),
    .o_valid     (o_valid),
    .o_error     (o_error),
    .o_err_code  (o_err_code),
    .o_busy      (o_busy)
  );

  always #5 i_clk = ~i_clk;
  always @(posedge i_clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference ALU from the opcode table; returns -1 for an unsupported opcode.
  function automatic int model(input int a, input int b, input int op);
    int sh;
    int sa;
    int r;
    sh = b % 8;
    sa = (a > 127) ? a - 256 : a;
    case (op)
      32: r = a + b;
      34: r = a - b;
      36: r = a & b;
      37: r = a | b;
      38: r = a ^ b;
      39: r = ~(a | b);
      3:  r = sa >>> sh;
      2:  r = a >> sh;
      default: return -1;
    endcase
    return r & 255;
  endfunction

  // Monitor: compares every popped result and every error pulse.
  initial begin
    forever begin
      @(negedge i_clk);
      if (o_valid && i_ready_tx) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_result: got 0x%0h, expected nothing", o_resultado);
        end else begin
          logic [7:0] e;
          e = exp_q.pop_front();
          $display("[TB] cycle %0d pop result 0x%02h (model 0x%02h)", cyc, o_resultado, e);
          check("result", o_resultado, e);
        end
      end
      if (o_error) begin
        err_seen++;
        err_cyc = cyc;
        if (err_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_error: got code %0d, expected no error", o_err_code);
        end else begin
          check("err_code", o_err_code, err_q.pop_front());
        end
      end
    end
  end

  // Transmitter: ready follows tx_en but drops for one cycle after each accept.
  initial begin
    bit took;
    forever begin
      @(negedge i_clk);
      took = o_valid && i_ready_tx;
      @(posedge i_clk);
      #1;
      i_ready_tx = took ? 1'b0 : tx_en;
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge i_clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] d);
    i_valid_rx = 1'b1;
    i_data     = d;
    @(posedge i_clk);
    #1;
    i_valid_rx = 1'b0;
  endtask

  task automatic frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] d,
                       input int g1, input int g2);
    int r;
    r = model(a, b, d & 8'h3F);
    if (r < 0) err_q.push_back(2'b01);
    else       exp_q.push_back(8'(r));
    send_byte(a);
    idle(g1);
    send_byte(b);
    idle(g2);
    send_byte(d);
  endtask

  task automatic wait_drain(input string name);
    int i;
    i = 0;
    while (exp_q.size() != 0 && i < 300) begin
      @(posedge i_clk);
      #1;
      i++;
    end
    check(name, exp_q.size(), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int k;
    int s;
    int ops[8];
    ops = '{32, 34, 36, 37, 38, 39, 3, 2};

    // Reset state
    repeat (3) @(posedge i_clk);
    #1;
    check("rst_valid", o_valid, 0);
    check("rst_result", o_resultado, 0);
    check("rst_error", o_error, 0);
    check("rst_err_code", o_err_code, 0);
    check("rst_busy", o_busy, 0);
    i_reset = 1'b1;
    tx_en   = 1'b1;
    idle(2);
    check("post_rst_busy", o_busy, 0);

    // ADD with latency check
    exp_q.push_back(8'(model(5, 3, 32)));
    send_byte(8'h05);
    send_byte(8'h03);
    check("busy_mid_frame", o_busy, 1);
    send_byte(8'h20);
    check("add_latency_n1", o_valid, 0);
    idle(1);
    check("add_latency_n2", o_valid, 1);
    check("add_value", o_resultado, 8'h08);
    idle(3);

    frame(8'h03, 8'h05, 8'h22, 0, 0);
    idle(3);
    frame(8'h80, 8'h01, 8'h03, 0, 0);
    idle(3);
    frame(8'h80, 8'h01, 8'h02, 0, 0);
    idle(3);
    wait_drain("drain_basic");

    // Invalid opcode
    frame(8'h11, 8'h22, 8'h3F, 0, 0);
    idle(4);
    check("badop_busy", o_busy, 0);
    check("badop_code_held", o_err_code, 1);
    check("badop_err_consumed", err_q.size(), 0);

    // Timeout: the late byte becomes a new A
    err_q.push_back(2'b10);
    s = err_seen;
    send_byte(8'h05);
    k = cyc;
    for (int i = 0; i < 150 && err_seen == s; i++) begin
      @(posedge i_clk);
      #1;
    end
    check("tmo_fired", err_seen - s, 1);
    check("tmo_cycle", err_cyc - k, TMO);
    check("tmo_busy", o_busy, 0);
    check("tmo_code", o_err_code, 2);
    frame(8'h03, 8'h04, 8'h20, 0, 0);
    idle(2);
    wait_drain("drain_tmo");

    // Back-pressure: four results fill the FIFO, the fifth stalls in EXEC
    tx_en = 1'b0;
    idle(3);
    for (int f = 0; f < 5; f++) begin
      frame(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
            8'(ops[$urandom_range(0, 7)]), 0, 0);
      idle(1);
    end
    idle(3);
    check("bp_busy", o_busy, 1);
    check("bp_valid", o_valid, 1);
    err_q.push_back(2'b11);
    send_byte(8'hAA);
    idle(2);
    check("bp_overrun_seen", err_q.size(), 0);
    check("bp_overrun_code", o_err_code, 3);
    check("bp_still_busy", o_busy, 1);
    tx_en = 1'b1;
    wait_drain("drain_bp");
    idle(3);
    check("bp_busy_after", o_busy, 0);
    check("bp_valid_after", o_valid, 0);

    // Reset in the middle of a frame
    send_byte(8'h05);
    send_byte(8'h03);
    i_reset = 1'b0;
    #1;
    check("mid_rst_busy", o_busy, 0);
    check("mid_rst_code", o_err_code, 0);
    check("mid_rst_valid", o_valid, 0);
    check("mid_rst_error", o_error, 0);
    @(posedge i_clk);
    #1;
    i_reset = 1'b1;
    idle(1);
    frame(8'h02, 8'h03, 8'h24, 0, 0);
    idle(3);
    wait_drain("drain_mid_rst");

    // Randomized frames, some with bad opcodes or an overrun byte
    for (int f = 0; f < 40; f++) begin
      logic [7:0] a;
      logic [7:0] b;
      logic [7:0] d;
      bit         ovr;
      a = 8'($urandom_range(0, 255));
      b = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 4) == 0) d = 8'($urandom_range(0, 255));
      else d = {2'($urandom_range(0, 3)), 6'(ops[$urandom_range(0, 7)])};
      ovr = (model(a, b, d & 8'h3F) >= 0) && ($urandom_range(0, 9) == 0);
      frame(a, b, d, $urandom_range(0, 5), $urandom_range(0, 5));
      if (ovr) begin
        err_q.push_back(2'b11);
        send_byte(8'h5A);
      end
      idle($urandom_range(1, 4));
    end
    wait_drain("drain_random");
    idle(4);
    check("errors_all_seen", err_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/uart_alu_sequencer.md
Name: uart_alu_sequencer

Overview:
- Parametrised successor to the single-frame UART/ALU interface.
- Collects frames {operand A, operand B, opcode} from the UART receiver's byte stream and executes the ALU operation internally.
- Queues results in a small FIFO that drains into the UART transmitter through a valid/ready handshake.
- Adds beyond the first generation: an inter-byte timeout, opcode checking, back-pressure buffering and error reporting.

Parameters:
- NB_DATA, 8, operand/result width and UART byte width.
- NB_OP, 6, opcode width; the opcode is taken from i_data[NB_OP-1:0], upper bits ignored.
- LOG_DEPTH, 2, result FIFO depth = 2**LOG_DEPTH entries.
- TIMEOUT_CYCLES, 800000, max i_clk cycles allowed between bytes of one frame (10 ms at 80 MHz).

Ports:
- i_clk  in  1  system clock
- i_reset  in  1  asynchronous, active-low reset
- i_valid_rx  in  1  one-cycle pulse: i_data holds a received byte
- i_data  in  NB_DATA  received byte
- i_ready_tx  in  1  transmitter can accept a byte
- o_resultado  out  NB_DATA  FIFO head byte
- o_valid  out  1  FIFO non-empty
- o_error  out  1  one-cycle pulse on frame error
- o_err_code  out  2  cause of last error: 01 bad opcode, 10 timeout, 11 overrun; held until next error
- o_busy  out  1  frame in progress (state != GET_A)

Behaviour:
- Reset (asynchronous assert, synchronous release), all outputs and state:
  - state = GET_A
  - FIFO empty, o_valid = 0, o_resultado = 0
  - o_error = 0, o_err_code = 00, timeout counter = 0
- States:
  - GET_A: on i_valid_rx, latch A -> GET_B.
  - GET_B: on i_valid_rx, latch B -> GET_OP.
  - GET_OP: on i_valid_rx, latch OP -> EXEC.
  - EXEC: if OP valid and FIFO not full, push result -> GET_A. If FIFO full, hold EXEC, no push. If OP invalid, error 01, no push -> GET_A.
- Timeout:
  - Counter clears on every accepted byte and counts in GET_B/GET_OP.
  - Reaching TIMEOUT_CYCLES-1 in either state: o_error pulse, code 10, frame discarded -> GET_A.
  - No timeout in GET_A or EXEC.
- Overrun: i_valid_rx while in EXEC drops the byte, pulses o_error with code 11, and the frame in EXEC still completes.
- Opcodes (MIPS function codes), results truncated to NB_DATA:
  - ADD 0x20 A+B
  - SUB 0x22 A-B
  - AND 0x24
  - OR 0x25
  - XOR 0x26
  - NOR 0x27
  - SRA 0x03 A>>>B[$clog2(NB_DATA)-1:0] (signed)
  - SRL 0x02 A>>B (same shift amount)
  - Any other code is invalid.
- Latency: opcode byte accepted in cycle N -> EXEC in N+1 -> o_valid high in N+2 (FIFO previously empty).
- Output handshake:
  - A pop occurs in any cycle with o_valid & i_ready_tx.
  - o_resultado shows the new head next cycle.
  - The transmitter must deassert i_ready_tx the cycle after accepting a byte.
  - A push and a pop in the same cycle are both performed, count unchanged. This is legal even when the FIFO is full: the pop frees a slot, so EXEC completes.
- FIFO pointers wrap modulo 2**LOG_DEPTH. Full/empty are decided by an extra pointer bit.
- o_error and a push never occur in the same cycle for the same frame.

Optional Feature:
- UART_ALU_FLAGS_EN defined:
  - Each valid operation pushes two bytes: the result, then a flags byte {NB_DATA-3 zeros, overflow, carry, zero}.
  - carry: carry-out of ADD, borrow of SUB, 0 otherwise.
  - overflow: signed overflow of ADD/SUB, 0 otherwise.
  - zero: result == 0.
  - EXEC waits until two slots are free; simultaneous pop counts as one slot freed.
- Undefined: single result byte only, and no flag logic is synthesised.

Decomposition:
- Package uart_alu_pkg holds:
  - opcode localparams (OP_ADD … OP_SRL)
  - state encoding (GET_A, GET_B, GET_OP, EXEC)
  - error codes (ERR_OP, ERR_TMO, ERR_OVR)
- One sub-module: sync_fifo (parameters NB_DATA, LOG_DEPTH), providing push, pop, full, empty and count ports. It is also reused for the FLAGS two-slot check.
- The ALU is a combinational function inside the top module.

Test Plan:
- Basic ADD and SUB:
  - Bytes 0x05, 0x03, 0x20 with i_ready_tx=1 -> o_valid two cycles after the third byte, o_resultado=0x08, popped once.
  - Bytes 0x03, 0x05, 0x22 -> 0xFE.
- SRA: bytes 0x80, 0x01, 0x03 -> 0xC0. Bytes 0x80, 0x01, 0x02 (SRL) -> 0x40.
- Invalid opcode: bytes 0x11, 0x22, 0x3F -> o_error one-cycle pulse, o_err_code=01, no push, o_busy=0 afterwards.
- Timeout: send 0x05, wait TIMEOUT_CYCLES (set to 100 in test), send 0x03 -> o_error, code 10 at cycle 100 after the first byte. The later 0x03 is taken as a new A.
- Back-pressure: i_ready_tx=0, send 5 valid frames with LOG_DEPTH=2.
  - FIFO holds 4 results and the 5th stalls in EXEC with o_busy=1.
  - A 6th byte arriving then gives code 11.
  - Raising i_ready_tx drains all 5 results in order.
- Reset mid-frame: after bytes 0x05, 0x03, assert i_reset low for 1 cycle -> all outputs 0, FIFO empty, state GET_A. The next 3 bytes form a fresh frame.
